intersection_scheduler: RTL and testbench

//   Two-approach intersection scheduler: sequences NS and EW signal heads through

---
 rtl/intersection_scheduler.sv | 176 +++++++++++++++++
 tb/tb_intersection_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_scheduler
// Purpose  : Two-approach (NS/EW) signal scheduler. Steps through
//            green / yellow / all-red with a protected pedestrian WALK.
//            It is demand-actuated, with latched vehicle and pedestrian
//            requests. Each green has a minimum time, a gap-out and a
//            max-out. NS rests in green when there is no opposing demand.
// Revision : 1.0  initial release
// ============================================================================
module intersection_scheduler #(
    parameter int CW      = 12,
    parameter int T_MIN_G = 128,
    parameter int T_MAX_G = 1024,
    parameter int T_Y     = 512,
    parameter int T_AR    = 128,
    parameter int T_WALK  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       veh_ns,
    input  logic       veh_ew,
    input  logic       ped_req,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
    } state_t;

    // Each interval ends on the cycle where the timer holds its last count.
    localparam logic [CW-1:0] MIN_LAST  = CW'(T_MIN_G - 1);
    localparam logic [CW-1:0] MAX_LAST  = CW'(T_MAX_G - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(T_Y - 1);
    localparam logic [CW-1:0] AR_LAST   = CW'(T_AR - 1);
    localparam logic [CW-1:0] WALK_LAST = CW'(T_WALK - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic            ns_pend_q, ns_pend_d;
    logic            ew_pend_q, ew_pend_d;
    logic            ped_pend_q, ped_pend_d;
    logic            next_ew_q, next_ew_d;
    logic            ns_r_q, ns_y_q, ns_g_q, ew_r_q, ew_y_q, ew_g_q, walk_q;
    logic            ns_r_d, ns_y_d, ns_g_d, ew_r_d, ew_y_d, ew_g_d, walk_d;
    logic            dem_vs_ns, dem_vs_ew, in_green;

    // Next-state selection: gap-out / max-out in greens, fixed-length elsewhere.
    always_comb begin
        state_d   = state_q;
        next_ew_d = next_ew_q;
        // Raw inputs count toward demand in the cycle they are first seen.
        dem_vs_ns = ew_pend_q | veh_ew | ped_pend_q | ped_req;
        dem_vs_ew = ns_pend_q | veh_ns | ped_pend_q | ped_req;
        case (state_q)
            NS_G: if (dem_vs_ns && (timer_q >= MIN_LAST) &&
                      (!veh_ns || (timer_q == MAX_LAST))) state_d = NS_Y;
            NS_Y: if (timer_q == Y_LAST) state_d = AR1;
            AR1: begin
                if (timer_q == AR_LAST) begin
                    if (ped_pend_q) begin
                        state_d   = WALK;
                        next_ew_d = 1'b1;
                    end else begin
                        state_d   = EW_G;
                    end
                end
            end
            EW_G: if (dem_vs_ew && (timer_q >= MIN_LAST) &&
                      (!veh_ew || (timer_q == MAX_LAST))) state_d = EW_Y;
            EW_Y: if (timer_q == Y_LAST) state_d = AR2;
            AR2: begin
                if (timer_q == AR_LAST) begin
                    if (ped_pend_q) begin
                        state_d   = WALK;
                        next_ew_d = 1'b0;
                    end else begin
                        state_d   = NS_G;
                    end
                end
            end
            WALK: if (timer_q == WALK_LAST) state_d = next_ew_q ? EW_G : NS_G;
            default: state_d = NS_G;
        endcase
    end

    // Phase timer: restarts on every transition, saturates while a green rests.
    always_comb begin
        in_green = (state_q == NS_G) || (state_q == EW_G);
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (in_green && (timer_q == MAX_LAST)) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + CW'(1);
        end
    end

    // Request latches: set outside the serving phase, cleared on its entry (clear wins).
    always_comb begin
        ns_pend_d  = ns_pend_q  | (veh_ns  && (state_q != NS_G));
        ew_pend_d  = ew_pend_q  | (veh_ew  && (state_q != EW_G));
        ped_pend_d = ped_pend_q | (ped_req && (state_q != WALK));
        if ((state_d == NS_G) && (state_q != NS_G)) ns_pend_d  = 1'b0;
        if ((state_d == EW_G) && (state_q != EW_G)) ew_pend_d  = 1'b0;
        if ((state_d == WALK) && (state_q != WALK)) ped_pend_d = 1'b0;
    end

    // Lamp decode of the upcoming state so the registered lamps track the state register.
    always_comb begin
        ns_g_d = (state_d == NS_G);
        ns_y_d = (state_d == NS_Y);
        ns_r_d = !(ns_g_d || ns_y_d);
        ew_g_d = (state_d == EW_G);
        ew_y_d = (state_d == EW_Y);
        ew_r_d = !(ew_g_d || ew_y_d);
        walk_d = (state_d == WALK);
    end

    // All state and output flops; asynchronous reset parks the junction in NS green.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NS_G;
            timer_q    <= '0;
            ns_pend_q  <= 1'b0;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
            next_ew_q  <= 1'b0;
            ns_r_q     <= 1'b0;
            ns_y_q     <= 1'b0;
            ns_g_q     <= 1'b1;
            ew_r_q     <= 1'b1;
            ew_y_q     <= 1'b0;
            ew_g_q     <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ns_pend_q  <= ns_pend_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
            next_ew_q  <= next_ew_d;
            ns_r_q     <= ns_r_d;
            ns_y_q     <= ns_y_d;
            ns_g_q     <= ns_g_d;
            ew_r_q     <= ew_r_d;
            ew_y_q     <= ew_y_d;
            ew_g_q     <= ew_g_d;
            walk_q     <= walk_d;
        end
    end

    assign ns_r  = ns_r_q;
    assign ns_y  = ns_y_q;
    assign ns_g  = ns_g_q;
    assign ew_r  = ew_r_q;
    assign ew_y  = ew_y_q;
    assign ew_g  = ew_g_q;
    assign walk  = walk_q;
    assign phase = state_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_scheduler
// Purpose  : Scoreboard bench for intersection_scheduler. It uses directed
//            scenarios followed by random demand. A reference model predicts
//            the phase and lamps after every clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_intersection_scheduler;

    localparam int CW      = 12;
    localparam int T_MIN_G = 4;
    localparam int T_MAX_G = 8;
    localparam int T_Y     = 2;
    localparam int T_AR    = 1;
    localparam int T_WALK  = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       veh_ns  = 1'b0;
    logic       veh_ew  = 1'b0;
    logic       ped_req = 1'b0;
    logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk;
    logic [2:0] phase;
    logic [6:0] act_lamps;

    intersection_scheduler #(
        .CW(CW), .T_MIN_G(T_MIN_G), .T_MAX_G(T_MAX_G),
        .T_Y(T_Y), .T_AR(T_AR), .T_WALK(T_WALK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .veh_ns(veh_ns), .veh_ew(veh_ew),
        .ped_req(ped_req), .ns_r(ns_r), .ns_y(ns_y), .ns_g(ns_g),
        .ew_r(ew_r), .ew_y(ew_y), .ew_g(ew_g), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    assign act_lamps = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk};

    typedef struct packed {
        logic [2:0] ph;
        logic [6:0] lamps;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: phase 0..6, cycles spent so far in the phase (unbounded),
    // outstanding requests, and where WALK hands over to.
    int   m_ph, m_age;
    bit   m_nsp, m_ewp, m_pp, m_walk_to_ew;

    // Observed phase run lengths and WALK occurrences.
    int   last_len[8];
    int   run_len = 0;
    int   walk_entries = 0;
    logic [2:0] prev_ph = 3'd0;

    function automatic logic [6:0] lamps_for(input int p);
        logic nsg, nsy, ewg, ewy;
        nsg = (p == 0);
        nsy = (p == 1);
        ewg = (p == 3);
        ewy = (p == 4);
        return {!(nsg || nsy), nsy, nsg, !(ewg || ewy), ewy, ewg, (p == 6)};
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_age = 0;
        m_nsp = 0; m_ewp = 0; m_pp = 0; m_walk_to_ew = 0;
    endtask

    // One clock of the junction rules, given this cycle's inputs.
    task automatic model_step(input bit vn, input bit ve, input bit pr);
        int elapsed;
        int nx;
        bit nsp, ewp, pp;
        elapsed = m_age + 1;
        nx      = m_ph;
        nsp = m_nsp | (vn && m_ph != 0);
        ewp = m_ewp | (ve && m_ph != 3);
        pp  = m_pp  | (pr && m_ph != 6);
        case (m_ph)
            0: if ((m_ewp | ve | m_pp | pr) && elapsed >= T_MIN_G &&
                   (!vn || elapsed >= T_MAX_G)) nx = 1;
            3: if ((m_nsp | vn | m_pp | pr) && elapsed >= T_MIN_G &&
                   (!ve || elapsed >= T_MAX_G)) nx = 4;
            1, 4: if (elapsed >= T_Y) nx = m_ph + 1;
            2, 5: if (elapsed >= T_AR) begin
                if (m_pp) begin
                    nx = 6;
                    m_walk_to_ew = (m_ph == 2);
                end else begin
                    nx = (m_ph == 2) ? 3 : 0;
                end
            end
            6: if (elapsed >= T_WALK) nx = m_walk_to_ew ? 3 : 0;
            default: nx = 0;
        endcase
        if (nx != m_ph) begin
            m_age = 0;
            if (nx == 0) nsp = 0;
            if (nx == 3) ewp = 0;
            if (nx == 6) pp  = 0;
        end else begin
            m_age++;
        end
        m_ph = nx; m_nsp = nsp; m_ewp = ewp; m_pp = pp;
    endtask

    task automatic push_expect();
        exp_t e;
        e.ph    = m_ph[2:0];
        e.lamps = lamps_for(m_ph);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit vn, input bit ve, input bit pr);
        @(negedge clk);
        veh_ns = vn; veh_ew = ve; ped_req = pr;
        model_step(vn, ve, pr);
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Drive constant inputs until the model is about to enter the target phase.
    task automatic reach(input int target, input bit vn, input bit ve, input bit pr,
                         input int budget);
        int n;
        n = 0;
        do begin
            cycle(vn, ve, pr);
            n++;
        end while (m_ph != target && n < budget);
        if (m_ph != target) begin
            total++;
            bad++;
            $display("FAIL reach target=%0d model_phase=%0d budget expired", target, m_ph);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        veh_ns = 1'b0; veh_ew = 1'b0; ped_req = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);
        push_expect();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every presented cycle against the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                total++;
                if (phase !== mon_e.ph || act_lamps !== mon_e.lamps) begin
                    bad++;
                    $display("FAIL sb cyc=%0d phase got=%0d want=%0d lamps got=%b want=%b",
                             cyc, phase, mon_e.ph, act_lamps, mon_e.lamps);
                end
            end
            if (phase != prev_ph) begin
                last_len[prev_ph] = run_len;
                run_len = 1;
                if (phase == 3'd6) walk_entries++;
            end else begin
                run_len++;
            end
            prev_ph = phase;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w0;
        bit  rv_ns, rv_ew;
        model_reset();

        // Reset state while rst_n is held low.
        #12;
        check("reset phase", phase, 0);
        check("reset lamps", act_lamps, 7'b0011000);

        // Test 1: idle after reset, NS rests in green.
        release_reset();
        idle(50);

        // Test 2: one-cycle EW pulse, then EW rests in green.
        cycle(1'b0, 1'b1, 1'b0);
        idle(10);
        settle();
        check("t2 ns_y length", last_len[1], T_Y);
        check("t2 ar1 length", last_len[2], T_AR);
        check("t2 rest in ew_g", phase, 3);

        // Back to NS green, wait out its minimum.
        reach(0, 1'b1, 1'b0, 1'b0, 50);
        idle(6);

        // Test 3: EW held, NS pulse at EW timer 1 -> max-out.
        reach(3, 1'b0, 1'b1, 1'b0, 50);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        reach(0, 1'b0, 1'b1, 1'b0, 50);
        settle();
        check("t3 ew_g maxout length", last_len[3], T_MAX_G);
        check("t3 ew_y length", last_len[4], T_Y);
        check("t3 ar2 length", last_len[5], T_AR);

        // Test 4a: EW drops at timer 5 -> gap-out after 6 cycles.
        reach(3, 1'b0, 1'b1, 1'b0, 50);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        reach(0, 1'b0, 1'b0, 1'b0, 50);
        settle();
        check("t4 ew_g gapout length", last_len[3], 6);

        // Test 4b: EW high only for timer 0..2 -> minimum green.
        reach(3, 1'b0, 1'b1, 1'b0, 50);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        reach(0, 1'b0, 1'b0, 1'b0, 50);
        settle();
        check("t4 ew_g min length", last_len[3], T_MIN_G);

        // Test 5: pedestrian request from NS rest; a repeat during WALK is ignored.
        idle(8);
        w0 = walk_entries;
        cycle(1'b0, 1'b0, 1'b1);
        reach(6, 1'b0, 1'b0, 1'b0, 50);
        cycle(1'b0, 1'b0, 1'b1);
        reach(3, 1'b0, 1'b0, 1'b0, 50);
        idle(20);
        settle();
        check("t5 walk length", last_len[6], T_WALK);
        check("t5 single walk", walk_entries, w0 + 1);
        check("t5 rest in ew_g", phase, 3);

        // Test 6: asynchronous reset in EW yellow with a pedestrian request latched.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        veh_ns = 1'b0; veh_ew = 1'b0; ped_req = 1'b0;
        #1;
        check("t6 async phase", phase, 0);
        check("t6 async ns_g", ns_g, 1);
        check("t6 async ew_r", ew_r, 1);
        check("t6 async walk", walk, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        w0 = walk_entries;
        release_reset();
        idle(30);
        settle();
        check("t6 no walk after reset", walk_entries, w0);
        check("t6 rest in ns_g", phase, 0);

        // Random demand against the reference model.
        rv_ns = 1'b0;
        rv_ew = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rv_ns = ~rv_ns;
            if ($urandom_range(0, 9) == 0) rv_ew = ~rv_ew;
            cycle(rv_ns, rv_ew, ($urandom_range(0, 29) == 0));
        end
        idle(5);
        settle();
        check("queue drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
